// File: rtl/blink_sequencer.sv
// ---------------------------------------------------------------------------
// blink_sequencer
//
// Command-driven LED pattern controller. A command asks for a burst of
// i_cmd_count on/off pulses on a single LED; every burst is followed by a
// dark gap, and with i_cmd_repeat set the burst (pulses plus gap) repeats
// until i_abort. All timing is expressed in timebase ticks of TICK_DIV clocks.
//
// Parameters:
//   TICK_DIV  - clocks per timebase tick (>= 2)
//   ON_TICKS  - ticks the LED is lit per pulse (>= 1)
//   OFF_TICKS - ticks the LED is dark between pulses of a burst (>= 1)
//   GAP_TICKS - ticks the LED is dark after the last pulse of a burst (>= 1)
//
// Ports:
//   i_clk         - system clock, all logic on the rising edge
//   i_rst_n       - synchronous active-low reset
//   i_cmd_valid   - command request; held by the requester until ready
//   o_cmd_ready   - command can be accepted this cycle (combinational)
//   i_cmd_count   - pulses per burst (0 = no pulses, completes at once)
//   i_cmd_repeat  - 1 = repeat the burst until aborted
//   i_abort       - terminate any active burst without a done pulse
//   o_led         - LED drive, active high, registered
//   o_busy        - sequencer not idle
//   o_done        - one-cycle pulse on normal burst completion
// ---------------------------------------------------------------------------
module blink_sequencer #(
  parameter int unsigned TICK_DIV  = 12500000,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned GAP_TICKS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_count,
  input  logic       i_cmd_repeat,
  input  logic       i_abort,
  output logic       o_led,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  localparam int unsigned MAX_TICKS =
    (ON_TICKS > OFF_TICKS) ?
      ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
      ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);

  // The phase counter only ever holds 0..length-1; the +1 keeps the width
  // non-zero when every phase is a single tick.
  localparam int unsigned PHASE_W = $clog2(MAX_TICKS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PHASE_W-1:0] ON_LAST   = PHASE_W'(ON_TICKS - 1);
  localparam logic [PHASE_W-1:0] OFF_LAST  = PHASE_W'(OFF_TICKS - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP,
    S_FIN
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [TICK_W-1:0]    tick_cnt;
  logic [PHASE_W-1:0]   phase_cnt;
  logic [PHASE_W-1:0]   phase_last;
  logic [7:0]           remaining;
  logic [7:0]           count_lat;
  logic                 repeat_lat;
  logic                 led;
  logic                 done;

  logic                 running;
  logic                 tick;
  logic                 phase_end;
  logic                 accept;

  // Ready is held low during reset so nothing can be mistaken for an accept
  // while the registers are being cleared.
  assign o_cmd_ready = (state == S_IDLE) && !i_abort && i_rst_n;
  assign accept      = i_cmd_valid && o_cmd_ready;

  assign running = (state == S_ON) || (state == S_OFF) || (state == S_GAP);
  assign tick    = running && (tick_cnt == TICK_LAST);

  assign o_led  = led;
  assign o_busy = (state != S_IDLE);
  assign o_done = done;

  // NOTE: every signal written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    phase_last = '0;
    state_next = state;

    unique case (state)
      S_ON:    phase_last = ON_LAST;
      S_OFF:   phase_last = OFF_LAST;
      S_GAP:   phase_last = GAP_LAST;
      default: phase_last = '0;
    endcase

    phase_end = tick && (phase_cnt == phase_last);

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (i_cmd_count != 8'd0) ? S_ON : S_FIN;
        end
      end
      S_ON: begin
        if (phase_end) begin
          state_next = (remaining == 8'd1) ? S_GAP : S_OFF;
        end
      end
      S_OFF: begin
        if (phase_end) begin
          state_next = S_ON;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          state_next = repeat_lat ? S_ON : S_FIN;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Abort wins over any phase transition; in IDLE it simply keeps IDLE.
    if (i_abort) begin
      state_next = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      phase_cnt  <= '0;
      remaining  <= '0;
      count_lat  <= '0;
      repeat_lat <= 1'b0;
      led        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      // Registered from the next state so o_led tracks (state == ON) exactly.
      led   <= (state_next == S_ON);
      done  <= (state == S_FIN) && !i_abort;

      if (accept) begin
        count_lat  <= i_cmd_count;
        repeat_lat <= i_cmd_repeat;
        remaining  <= i_cmd_count;
        tick_cnt   <= '0;
        phase_cnt  <= '0;
      end else if (i_abort) begin
        tick_cnt  <= '0;
        phase_cnt <= '0;
      end else begin
        if (running) begin
          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end

        if (state_next != state) begin
          phase_cnt <= '0;
        end else if (tick) begin
          phase_cnt <= phase_cnt + PHASE_W'(1);
        end

        if ((state == S_ON) && phase_end) begin
          remaining <= remaining - 8'd1;
        end else if ((state == S_GAP) && phase_end && repeat_lat) begin
          remaining <= count_lat;
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// ---------------------------------------------------------------------------
// tb_blink_sequencer
//
// Scoreboard bench for blink_sequencer (TICK_DIV=4, ON=2, OFF=1, GAP=3).
// The driver chooses the inputs for each cycle and pushes the expected
// outputs of that cycle into a queue. Expected outputs come from a waveform
// plan: on accept, the whole burst is laid out cycle by cycle from the
// pulse/gap lengths, and each cycle pops one entry. A separate monitor pops
// the queue on the falling edge and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_blink_sequencer;

  localparam int unsigned DIV   = 4;
  localparam int unsigned ON_T  = 2;
  localparam int unsigned OFF_T = 1;
  localparam int unsigned GAP_T = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_count;
  logic       cmd_repeat;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;

  blink_sequencer #(
    .TICK_DIV (DIV),
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T),
    .GAP_TICKS(GAP_T)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_count (cmd_count),
    .i_cmd_repeat(cmd_repeat),
    .i_abort     (abort),
    .o_led       (led),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic led;
    logic busy;
    logic done;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic ready;
  } sb_t;

  exp_t        plan[$];
  sb_t         sb_q[$];
  exp_t        cur;
  bit          rep_active;
  int unsigned rep_n;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  function automatic exp_t mk(logic l, logic b, logic d);
    exp_t r;
    r.led  = l;
    r.busy = b;
    r.done = d;
    return r;
  endfunction

  // Lay out one burst: n pulses, OFF between them, GAP after the last.
  // A one-shot (or empty) burst ends with one FIN cycle and one done cycle.
  function automatic void add_burst(int unsigned n, bit rep);
    for (int unsigned p = 1; p <= n; p++) begin
      for (int unsigned c = 0; c < ON_T * DIV; c++) plan.push_back(mk(1'b1, 1'b1, 1'b0));
      for (int unsigned c = 0; c < ((p == n) ? GAP_T : OFF_T) * DIV; c++)
        plan.push_back(mk(1'b0, 1'b1, 1'b0));
    end
    if (!rep || n == 0) begin
      plan.push_back(mk(1'b0, 1'b1, 1'b0));
      plan.push_back(mk(1'b0, 1'b0, 1'b1));
    end
  endfunction

  function automatic exp_t next_exp();
    if (plan.size() == 0 && rep_active) add_burst(rep_n, 1'b1);
    if (plan.size() == 0) return mk(1'b0, 1'b0, 1'b0);
    return plan.pop_front();
  endfunction

  task automatic check(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  // One clock cycle of stimulus plus the model step for the following cycle.
  task automatic drive(input bit v, input int unsigned cnt, input bit rep,
                       input bit ab, input bit rn);
    sb_t s;
    @(posedge clk);
    #1;
    cyc++;
    cmd_valid  = v;
    cmd_count  = cnt[7:0];
    cmd_repeat = rep;
    abort      = ab;
    rst_n      = rn;
    s.e     = cur;
    s.ready = !cur.busy && !ab && rn;
    sb_q.push_back(s);
    if (!rn || (ab && cur.busy)) begin
      plan.delete();
      rep_active = 1'b0;
      cur = mk(1'b0, 1'b0, 1'b0);
    end else begin
      if (v && s.ready) begin
        plan.delete();
        rep_active = rep && (cnt != 0);
        rep_n      = cnt;
        add_burst(cnt, rep);
      end
      cur = next_exp();
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    sb_t s;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      check("led",   led,       s.e.led);
      check("busy",  busy,      s.e.busy);
      check("done",  done,      s.e.done);
      check("ready", cmd_ready, s.ready);
    end
  end

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b1;
    cmd_count  = 8'd5;
    cmd_repeat = 1'b0;
    abort      = 1'b0;
    cur        = mk(1'b0, 1'b0, 1'b0);
    rep_active = 1'b0;
    rep_n      = 0;

    // Reset held with valid asserted: nothing accepted, ready low.
    for (int i = 0; i < 3; i++) drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Single burst of 3 pulses.
    drive(1'b1, 3, 1'b0, 1'b0, 1'b1);
    idle(50);

    // Zero-count command: FIN then done, LED stays dark.
    drive(1'b1, 0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Repeat, abort mid-ON of the third burst, new command right after.
    drive(1'b1, 1, 1'b1, 1'b0, 1'b1);
    idle(44);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 2, 1'b0, 1'b0, 1'b1);
    idle(40);

    // Command while busy is ignored; abort+valid in IDLE is not accepted.
    drive(1'b1, 3, 1'b0, 1'b0, 1'b1);
    idle(5);
    for (int i = 0; i < 3; i++) drive(1'b1, 1, 1'b1, 1'b0, 1'b1);
    idle(45);
    drive(1'b1, 2, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Reset during OFF, then a fresh two-pulse burst.
    drive(1'b1, 2, 1'b0, 1'b0, 1'b1);
    idle(10);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 2, 1'b0, 1'b0, 1'b1);
    idle(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) == 0, $urandom % 5, ($urandom % 6) == 0,
            ($urandom % 60) == 0, ($urandom % 200) != 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Command-driven LED pattern controller that sequences a single LED output through a requested number of on/off pulses.
- Each burst is followed by an inter-burst gap. Bursts can optionally repeat until aborted.
- Sits between board-level status logic (boot, error and link FSMs) and a board LED pin, replacing a free-running blinker where a countable, abortable pattern is needed.

Parameters:
- TICK_DIV, 12500000: clocks per timebase tick; legal range ≥ 2.
- ON_TICKS, 2: ticks the LED is lit per pulse; legal range ≥ 1.
- OFF_TICKS, 2: ticks the LED is dark between pulses within a burst; legal range ≥ 1.
- GAP_TICKS, 8: ticks the LED is dark after the last pulse of a burst; legal range ≥ 1.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_cmd_valid  input  1  command request.
- o_cmd_ready  output  1  command can be accepted this cycle.
- i_cmd_count  input  8  pulses per burst.
- i_cmd_repeat  input  1  1 = repeat the burst until aborted.
- i_abort  input  1  terminate any active burst.
- o_led  output  1  LED drive, active high, registered.
- o_busy  output  1  sequencer not idle.
- o_done  output  1  one-cycle pulse on normal burst completion.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n and overrides everything.
- Reset state: IDLE; o_led=0, o_busy=0, o_done=0; tick and phase counters cleared; latched count and repeat flag cleared.
- States: IDLE, ON, OFF, GAP, FIN.
- o_cmd_ready = (state==IDLE) && !i_abort. This output is combinational from state and i_abort.
- Accept: i_cmd_valid && o_cmd_ready at edge k.
  - Latch count and repeat.
  - Clear the tick counter and phase counter.
  - Next state: ON if count≠0, otherwise FIN.
- Timebase:
  - The tick counter runs only outside IDLE and FIN. It counts 0..TICK_DIV-1 and wraps.
  - A tick is asserted in the cycle the counter equals TICK_DIV-1.
  - The phase counter increments on each tick and clears on every state change.
- Phase exits: a phase ends on the tick that makes (phase counter + 1) equal its length. Each phase therefore lasts exactly length × TICK_DIV clocks.
- ON (o_led=1):
  - At phase end, decrement the remaining count.
  - If remaining was 1, go to GAP; otherwise go to OFF.
- OFF (o_led=0): at phase end, go to ON.
- GAP (o_led=0): at phase end:
  - if repeat=1, reload the latched count and go to ON;
  - otherwise go to FIN.
- FIN: lasts one cycle, then IDLE. o_done=1 in the first IDLE cycle only, i.e. o_done is registered and asserted for exactly one cycle.
- o_led is registered and equals (state==ON).
- o_busy = (state≠IDLE).
- Latency:
  - o_led rises in the cycle after the accept edge.
  - count=0 command: FIN for one cycle after accept; o_done two cycles after accept; o_led stays 0.
- Abort:
  - i_abort=1 in any non-IDLE state forces IDLE at the next edge: o_led=0, counters cleared, o_done NOT asserted.
  - In IDLE, abort only blocks acceptance (ready=0) and has no other effect.
  - Abort has priority over every phase transition in the same cycle.
- Command hold: i_cmd_valid while busy is ignored and not queued. The requester must hold valid until it sees ready.
- Reset mid-burst: i_rst_n=0 at any edge returns all registers to their reset values. No o_done pulse is generated.
- Counter widths:
  - Tick counter: $clog2(TICK_DIV) bits.
  - Phase counter: wide enough for the maximum of ON_TICKS, OFF_TICKS and GAP_TICKS.
  - Remaining count: 8 bits. It never underflows, because ON exits to GAP at remaining=1.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3):
- Reset: hold i_rst_n=0 for 3 cycles with i_cmd_valid=1 → o_led=0, o_busy=0, o_done=0, o_cmd_ready=0 throughout. After release, o_cmd_ready=1.
- Single burst: count=3, repeat=0, accept at cycle 0 →
  - o_led high for cycles 1–8, 13–20 and 25–32;
  - low for cycles 9–12, 21–24 and 33–44;
  - cycle 45 is FIN; o_done=1 at cycle 46 only; o_busy=1 for cycles 1–45.
- Zero count: count=0 → o_led stays 0, o_busy=1 for cycle 1 only, o_done=1 at cycle 2.
- Repeat then abort: count=1, repeat=1 →
  - o_led high 8 cycles, low 12 cycles, repeating;
  - abort asserted mid-ON of the 3rd burst → o_led=0 and o_busy=0 the next cycle, no o_done pulse;
  - a new command is accepted the following cycle.
- Busy ignore: issue a second command during a burst → o_cmd_ready=0 and the command is not latched; the first burst timing is unchanged. Then assert abort and valid together in IDLE → not accepted.
- Reset mid-burst: drive i_rst_n=0 during OFF → the next cycle shows o_led=0, o_busy=0, no o_done. A fresh count=2 command then produces exactly 2 pulses.
